// File: rtl/axis_tx_arb_pkg.sv
// Shared types and the round-robin pick helper for the GMII TX frame arbiter.
package axis_tx_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int RR_MAX_PORTS = 32;
    localparam int RR_IDX_W     = 5;

    // Returns {found, index}: first set bit of req scanning cyclically from ptr over count ports.
    function automatic logic [RR_IDX_W:0] rr_pick(
        input logic [RR_MAX_PORTS-1:0] req,
        input logic [RR_IDX_W-1:0]     ptr,
        input int unsigned             count
    );
        logic                found;
        logic [RR_IDX_W-1:0] idx;
        logic [RR_IDX_W-1:0] cand_idx;
        int unsigned         cand;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < RR_MAX_PORTS; i++) begin
            if (i < count) begin
                cand = 32'(ptr) + i;
                if (cand >= count) begin
                    cand = cand - count;
                end else begin
                    cand = cand;
                end
                cand_idx = cand[RR_IDX_W-1:0];
                if (!found && req[cand_idx]) begin
                    found = 1'b1;
                    idx   = cand_idx;
                end else begin
                    found = found;
                end
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/axis_tx_out_reg.sv
// Single-entry AXI-Stream output register slice feeding the MAC.
module axis_tx_out_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] beat_data,
    input  logic                  beat_last,
    input  logic [USER_WIDTH-1:0] beat_user,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser
);

    logic [DATA_WIDTH-1:0] data_r;
    logic                  valid_r;
    logic                  last_r;
    logic [USER_WIDTH-1:0] user_r;

    assign ready         = !valid_r || m_axis_tready;
    assign m_axis_tdata  = data_r;
    assign m_axis_tvalid = valid_r;
    assign m_axis_tlast  = last_r;
    assign m_axis_tuser  = user_r;

    // Holding register: contents only change on a load, so a stalled beat stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            user_r  <= '0;
        end else if (load) begin
            data_r  <= beat_data;
            valid_r <= 1'b1;
            last_r  <= beat_last;
            user_r  <= beat_user;
        end else if (m_axis_tready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

endmodule

// File: rtl/axis_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one GMII TX MAC between S_COUNT sources.
module axis_tx_frame_arbiter
    import axis_tx_arb_pkg::*;
#(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int GRANT_W    = (S_COUNT > 1 ? $clog2(S_COUNT) : 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    input  logic                          pause,
    output logic                          busy,
    output logic [GRANT_W-1:0]            grant_index,
    output logic                          frame_done,
    output logic [GRANT_W-1:0]            frame_done_index
);

    localparam int unsigned RR_COUNT = S_COUNT;

    arb_state_t            state_r;
    logic [GRANT_W-1:0]    rr_ptr_r;
    logic [GRANT_W-1:0]    grant_index_r;
    logic                  busy_r;
    logic                  frame_done_r;
    logic [GRANT_W-1:0]    frame_done_index_r;

    logic [RR_MAX_PORTS-1:0] req_ext_s;
    logic [RR_IDX_W-1:0]     ptr_ext_s;
    logic [RR_IDX_W:0]       pick_s;
    logic                    pick_found_s;
    logic [GRANT_W-1:0]      pick_index_s;
    logic                    pick_unused_s;
    logic [GRANT_W-1:0]      next_ptr_s;

    logic                  out_ready_s;
    logic                  load_s;
    logic [DATA_WIDTH-1:0] beat_data_s;
    logic                  beat_last_s;
    logic [USER_WIDTH-1:0] beat_user_s;

    assign busy             = busy_r;
    assign grant_index      = grant_index_r;
    assign frame_done       = frame_done_r;
    assign frame_done_index = frame_done_index_r;

    // Round-robin candidate for the next grant, widened to the helper's fixed port space.
    always_comb begin
        req_ext_s                 = '0;
        req_ext_s[S_COUNT-1:0]    = s_axis_tvalid;
        ptr_ext_s                 = '0;
        ptr_ext_s[GRANT_W-1:0]    = rr_ptr_r;
        pick_s                    = rr_pick(req_ext_s, ptr_ext_s, RR_COUNT);
        pick_found_s              = pick_s[RR_IDX_W];
        pick_index_s              = pick_s[GRANT_W-1:0];
        pick_unused_s             = ^pick_s[RR_IDX_W-1:GRANT_W];
    end

    // Pointer wraps to the port after the one that just finished; a single port keeps it at 0.
    always_comb begin
        if (grant_index_r == GRANT_W'(S_COUNT - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_index_r + {{(GRANT_W-1){1'b0}}, 1'b1};
        end
    end

    // Granted-port beat mux and handshake.
    always_comb begin
        beat_data_s   = s_axis_tdata[grant_index_r*DATA_WIDTH +: DATA_WIDTH];
        beat_last_s   = s_axis_tlast[grant_index_r];
        beat_user_s   = s_axis_tuser[grant_index_r*USER_WIDTH +: USER_WIDTH];
        s_axis_tready = '0;
        if (state_r == XFER) begin
            s_axis_tready[grant_index_r] = out_ready_s;
            load_s = s_axis_tvalid[grant_index_r] && out_ready_s;
        end else begin
            load_s = 1'b0;
        end
    end

    // Arbiter FSM: one idle cycle to grant, then the owner streams until its tlast is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r            <= IDLE;
            rr_ptr_r           <= '0;
            grant_index_r      <= '0;
            busy_r             <= 1'b0;
            frame_done_r       <= 1'b0;
            frame_done_index_r <= '0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!pause && pick_found_s) begin
                        grant_index_r <= pick_index_s;
                        busy_r        <= 1'b1;
                        state_r       <= XFER;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                XFER: begin
                    if (load_s && beat_last_s) begin
                        frame_done_r       <= 1'b1;
                        frame_done_index_r <= grant_index_r;
                        rr_ptr_r           <= next_ptr_s;
                        busy_r             <= 1'b0;
                        state_r            <= IDLE;
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    axis_tx_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .USER_WIDTH (USER_WIDTH)
    ) u_out_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load_s),
        .beat_data     (beat_data_s),
        .beat_last     (beat_last_s),
        .beat_user     (beat_user_s),
        .ready         (out_ready_s),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
    );

endmodule

// File: tb/tb_axis_tx_frame_arbiter.sv
// Scoreboard bench for axis_tx_frame_arbiter: queued source frames in, expected beats/completions checked by monitors.
module tb_axis_tx_frame_arbiter;

    localparam int S_COUNT = 4;
    localparam int DW      = 8;
    localparam int UW      = 1;
    localparam int GW      = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [S_COUNT*DW-1:0] s_axis_tdata;
    logic [S_COUNT-1:0]    s_axis_tvalid;
    logic [S_COUNT-1:0]    s_axis_tready;
    logic [S_COUNT-1:0]    s_axis_tlast;
    logic [S_COUNT*UW-1:0] s_axis_tuser;
    logic [DW-1:0]         m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic [UW-1:0]         m_axis_tuser;
    logic                  pause;
    logic                  busy;
    logic [GW-1:0]         grant_index;
    logic                  frame_done;
    logic [GW-1:0]         frame_done_index;

    axis_tx_frame_arbiter #(
        .S_COUNT    (S_COUNT),
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tuser     (s_axis_tuser),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser     (m_axis_tuser),
        .pause            (pause),
        .busy             (busy),
        .grant_index      (grant_index),
        .frame_done       (frame_done),
        .frame_done_index (frame_done_index)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    beat_t src_q[S_COUNT][$];
    beat_t exp_q[$];
    int    exp_done_q[$];
    int    grant_log[$];
    int    gap_log[$];
    int    beat_cyc[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic src_frame(input int p, input logic [7:0] base, input logic [7:0] step,
                             input int n, input logic ulast);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = base + 8'(i) * step;
            b.last = (i == n - 1);
            b.user = (i == n - 1) ? ulast : 1'b0;
            src_q[p].push_back(b);
        end
    endtask

    task automatic exp_frame(input int p, input logic [7:0] base, input logic [7:0] step,
                             input int n, input logic ulast);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = base + 8'(i) * step;
            b.last = (i == n - 1);
            b.user = (i == n - 1) ? ulast : 1'b0;
            exp_q.push_back(b);
        end
        exp_done_q.push_back(p);
    endtask

    function automatic logic all_idle();
        logic idle;
        idle = (exp_q.size() == 0) && (exp_done_q.size() == 0) && !busy;
        for (int p = 0; p < S_COUNT; p++) idle = idle && (src_q[p].size() == 0);
        return idle;
    endfunction

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!all_idle() && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(name, {31'd0, all_idle()}, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_busy(input string name);
        int k;
        k = 0;
        while (!busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(name, {31'd0, busy}, 32'd1);
    endtask

    // Source driver: presents the head of each port queue, pops on a handshake.
    initial begin
        logic [S_COUNT-1:0] acc;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        forever begin
            @(negedge clk);
            acc = s_axis_tvalid & s_axis_tready;
            @(posedge clk);
            #1;
            for (int p = 0; p < S_COUNT; p++) begin
                if (acc[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
                if (src_q[p].size() > 0) begin
                    s_axis_tvalid[p]         = 1'b1;
                    s_axis_tdata[p*DW +: DW] = src_q[p][0].data;
                    s_axis_tlast[p]          = src_q[p][0].last;
                    s_axis_tuser[p]          = src_q[p][0].user;
                end else begin
                    s_axis_tvalid[p]         = 1'b0;
                    s_axis_tdata[p*DW +: DW] = 8'h00;
                    s_axis_tlast[p]          = 1'b0;
                    s_axis_tuser[p]          = 1'b0;
                end
            end
        end
    end

    // Output monitor: scoreboard pops on every accepted output beat and completion pulse.
    initial begin
        beat_t e;
        int    d;
        logic  busy_prev;
        int    low_run;
        busy_prev = 1'b0;
        low_run   = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat: got data 0x%0h expected none", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", {24'd0, m_axis_tdata}, {24'd0, e.data});
                        chk("beat_last", {31'd0, m_axis_tlast}, {31'd0, e.last});
                        chk("beat_user", {31'd0, m_axis_tuser}, {31'd0, e.user});
                        beat_cyc.push_back(cyc);
                    end
                end
                if (frame_done) begin
                    if (exp_done_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: got index %0d expected none", frame_done_index);
                    end else begin
                        d = exp_done_q.pop_front();
                        chk("done_index", {30'd0, frame_done_index}, 32'(d));
                    end
                end
                if (busy && !busy_prev) begin
                    grant_log.push_back(int'(grant_index));
                    gap_log.push_back(low_run);
                end
                low_run   = busy ? 0 : low_run + 1;
                busy_prev = busy;
            end else begin
                busy_prev = 1'b0;
                low_run   = 0;
            end
        end
    end

    initial begin
        m_axis_tready = 1'b1;
        pause         = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rst_m_tdata", {24'd0, m_axis_tdata}, 32'd0);
        chk("rst_m_tlast", {31'd0, m_axis_tlast}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_grant", {30'd0, grant_index}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_done_idx", {30'd0, frame_done_index}, 32'd0);
        chk("rst_s_tready", {28'd0, s_axis_tready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Port 0 three-beat frame, back-to-back output beats.
        beat_cyc.delete();
        src_frame(0, 8'h11, 8'h11, 3, 1'b0);
        exp_frame(0, 8'h11, 8'h11, 3, 1'b0);
        wait_idle("t1_idle");
        chk("t1_beats", 32'(beat_cyc.size()), 32'd3);
        if (beat_cyc.size() == 3) chk("t1_consecutive", 32'(beat_cyc[2] - beat_cyc[0]), 32'd2);

        // rr_ptr is now 1: port 1 wins over port 0.
        src_frame(0, 8'hAA, 8'h01, 1, 1'b0);
        src_frame(1, 8'hBB, 8'h01, 1, 1'b0);
        exp_frame(1, 8'hBB, 8'h01, 1, 1'b0);
        exp_frame(0, 8'hAA, 8'h01, 1, 1'b0);
        wait_idle("t1b_idle");

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Three contending ports from rr_ptr 0.
        grant_log.delete();
        gap_log.delete();
        src_frame(0, 8'h01, 8'h01, 2, 1'b0);
        src_frame(0, 8'h07, 8'h01, 2, 1'b0);
        src_frame(1, 8'h03, 8'h01, 2, 1'b0);
        src_frame(2, 8'h05, 8'h01, 2, 1'b0);
        exp_frame(0, 8'h01, 8'h01, 2, 1'b0);
        exp_frame(1, 8'h03, 8'h01, 2, 1'b0);
        exp_frame(2, 8'h05, 8'h01, 2, 1'b0);
        exp_frame(0, 8'h07, 8'h01, 2, 1'b0);
        wait_idle("t2_idle");
        chk("t2_grants", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4) begin
            chk("t2_grant0", 32'(grant_log[0]), 32'd0);
            chk("t2_grant1", 32'(grant_log[1]), 32'd1);
            chk("t2_grant2", 32'(grant_log[2]), 32'd2);
            chk("t2_grant3", 32'(grant_log[3]), 32'd0);
            for (int i = 1; i < 4; i++) chk("t2_gap", 32'(gap_log[i]), 32'd1);
        end

        // Port 3 with the MAC stalling for four cycles after the first beat.
        src_frame(3, 8'h31, 8'h01, 5, 1'b0);
        exp_frame(3, 8'h31, 8'h01, 5, 1'b0);
        wait_busy("t3_grant");
        @(posedge clk);
        #1;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_hold_data", {24'd0, m_axis_tdata}, 32'h31);
            chk("t3_hold_valid", {31'd0, m_axis_tvalid}, 32'd1);
            chk("t3_s_tready", {31'd0, s_axis_tready[3]}, 32'd0);
        end
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        wait_idle("t3_idle");

        // Pause withholds the grant; pause mid-frame does not cut it.
        pause = 1'b1;
        src_frame(1, 8'h41, 8'h01, 2, 1'b0);
        exp_frame(1, 8'h41, 8'h01, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_paused_busy", {31'd0, busy}, 32'd0);
            chk("t4_paused_tready", {28'd0, s_axis_tready}, 32'd0);
        end
        @(posedge clk);
        #1;
        pause = 1'b0;
        @(negedge clk);
        chk("t4_release_busy0", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("t4_release_busy1", {31'd0, busy}, 32'd1);
        chk("t4_release_grant", {30'd0, grant_index}, 32'd1);
        pause = 1'b1;
        wait_idle("t4_idle");
        pause = 1'b0;

        // Single-beat bad frame on port 2.
        src_frame(2, 8'h55, 8'h01, 1, 1'b1);
        exp_frame(2, 8'h55, 8'h01, 1, 1'b1);
        wait_idle("t5_idle");

        // Reset on the second beat of a 5-beat frame; only the first beat reaches the MAC.
        src_frame(1, 8'h61, 8'h01, 5, 1'b0);
        exp_q.push_back('{data: 8'h61, last: 1'b0, user: 1'b0});
        wait_busy("t6_grant");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_grant", {30'd0, grant_index}, 32'd0);
        chk("t6_s_tready", {28'd0, s_axis_tready}, 32'd0);
        src_q[1].delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        grant_log.delete();
        for (int p = 0; p < S_COUNT; p++) src_frame(p, 8'(8'h70 + p), 8'h01, 1, 1'b0);
        for (int p = 0; p < S_COUNT; p++) exp_frame(p, 8'(8'h70 + p), 8'h01, 1, 1'b0);
        wait_idle("t6_idle");
        chk("t6_grants", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t6_order", 32'(grant_log[i]), 32'(i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_tx_frame_arbiter.md
Name: axis_tx_frame_arbiter

Overview:
Frame-granular round-robin arbiter that shares one GMII transmit MAC (8-bit AXI-Stream frame input) between S_COUNT AXI-Stream frame sources.
- Once a source is granted, it owns the MAC until its tlast beat is accepted; frames are never interleaved.
- Sits directly upstream of the GMII TX MAC. The output is registered so the MAC sees a clean, glitch-free stream.
- Also provides a pause input that holds off new grants, plus per-frame completion status.

Parameters:
- S_COUNT, 4, number of source ports (≥1).
- DATA_WIDTH, 8, tdata width per port.
- USER_WIDTH, 1, tuser width per port; bit 0 is the bad-frame flag and is passed through untouched.
- GRANT_W, (S_COUNT>1 ? $clog2(S_COUNT) : 1), width of the port index (derived; do not override).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  source data; port i occupies slice i.
- s_axis_tvalid  in  S_COUNT  per-port valid.
- s_axis_tready  out  S_COUNT  per-port ready.
- s_axis_tlast  in  S_COUNT  per-port end of frame.
- s_axis_tuser  in  S_COUNT*USER_WIDTH  per-port user bits.
- m_axis_tdata  out  DATA_WIDTH  data to the MAC.
- m_axis_tvalid  out  1  valid to the MAC.
- m_axis_tready  in  1  ready from the MAC.
- m_axis_tlast  out  1  end of frame to the MAC.
- m_axis_tuser  out  USER_WIDTH  user bits to the MAC.
- pause  in  1  when high, no new grant is issued.
- busy  out  1  a grant is held.
- grant_index  out  GRANT_W  currently or last granted port.
- frame_done  out  1  one-cycle pulse when a tlast beat enters the output register.
- frame_done_index  out  GRANT_W  port that completed the frame; valid with frame_done.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, grant_index=0, busy=0, m_axis_tvalid=0, m_axis_tdata/tlast/tuser=0, s_axis_tready=0, frame_done=0, frame_done_index=0.
- FSM states: IDLE, XFER.
- IDLE, condition: pause==0 and |s_axis_tvalid.
  - Select the first port with tvalid=1, scanning cyclically from rr_ptr (rr_ptr, rr_ptr+1, …, wrapping S_COUNT-1→0).
  - Register grant_index, set busy=1, go to XFER.
  - No beat is accepted in the IDLE cycle; arbitration latency is exactly 1 cycle.
- IDLE with pause==1: stay in IDLE; all s_axis_tready=0.
- pause is sampled only in IDLE; asserting it mid-frame has no effect on the frame in progress.
- XFER ready rule: s_axis_tready[grant_index] = out_ready, where out_ready = !m_axis_tvalid || m_axis_tready. All other tready bits are 0.
- XFER beat accept: on s_tvalid & s_tready of the granted port, load the output register (data, last, user) and set m_axis_tvalid=1.
- Output register without a new load: m_axis_tvalid clears when m_axis_tready=1 and no new beat is loaded; otherwise it holds.
- Stall rule: output register contents are stable while m_axis_tvalid=1 and m_axis_tready=0.
- Granted source tvalid low mid-frame: no load, grant is retained. Underflow detection is the MAC's job.
- Accepted beat with tlast=1:
  - pulse frame_done with frame_done_index=grant_index;
  - rr_ptr ← (grant_index+1) mod S_COUNT;
  - busy ← 0; state ← IDLE.
- Inter-frame gap: minimum one idle input cycle between frames. Throughput is 1 beat/cycle within a frame.
- Single-beat frame (tlast on first beat): grant released in the same cycle that beat is accepted.
- S_COUNT=1: rr_ptr is held at 0; behaviour is otherwise identical.
- Simultaneous requests: the round-robin order guarantees each requesting port a grant within S_COUNT frames.
- Reset mid-frame: all state clears immediately and m_axis_tvalid drops. This is the sanctioned abort path; the MAC flags the truncated frame as underflow.

Decomposition:
- Package axis_tx_arb_pkg:
  - state enum (IDLE, XFER);
  - function rr_pick(req, ptr), returning {found, index}.
- Sub-module axis_tx_out_reg: single-entry output register slice (data/last/user/valid, ready = !valid || m_ready), with async active-low reset.
- The arbiter FSM stays in the top module.

Test Plan:
- Single port 0, 3-beat frame 0x11,0x22,0x33, m_tready=1 → m_axis outputs 0x11,0x22,0x33 on consecutive cycles; tlast on 0x33; frame_done=1 with index 0; next rr_ptr=1.
- Ports 0,1,2 all hold 2-beat frames continuously, rr_ptr=0 → grant order 0,1,2,0; each grant entered after exactly 1 IDLE cycle; no interleaving of beats between ports.
- Port 3 granted, m_tready low for 4 cycles mid-frame → m_axis_tdata holds its value; s_axis_tready[3]=0 for those cycles; no beat lost or duplicated.
- pause=1 while port 1 is valid → grant withheld and busy=0; on pause=0, grant to port 1 one cycle later. pause=1 asserted mid-frame → that frame completes.
- Port 2 beat with tuser=1 and tlast=1 → m_axis_tuser=1 delivered alongside tlast; grant released normally.
- rst_n asserted on the 2nd beat of a 5-beat frame → m_axis_tvalid=0, busy=0, rr_ptr=0 asynchronously; after release, arbitration restarts from port 0.
